// File: rtl/fp_div_pkg.sv
// Shared constants, select encodings and reciprocal seed table for the
// Goldschmidt mantissa divider.
package fp_div_pkg;

    localparam int unsigned Q_W = 27;
    localparam logic [Q_W-1:0] ONE_Q126 = 27'h4000000;

    typedef enum logic [1:0] {
        MCAND_NUM = 2'b00,
        MCAND_DEN = 2'b01,
        MCAND_A   = 2'b10,
        MCAND_B   = 2'b11
    } mcand_sel_e;

    typedef enum logic [1:0] {
        MPLIER_SEED = 2'b00,
        MPLIER_C    = 2'b01,
        MPLIER_DEN  = 2'b10,
        MPLIER_ONE  = 2'b11
    } mplier_sel_e;

    // Entry k = round(2^26 / (1 + (k + 0.5) / 16)): reciprocal of each bucket midpoint.
    localparam logic [Q_W-1:0] SEED_ROM [16] = '{
        27'd65075262, 27'd61356676, 27'd58040099, 27'd55063683,
        27'd52377650, 27'd49941480, 27'd47721859, 27'd45691141,
        27'd43826197, 27'd42107523, 27'd40518559, 27'd39045157,
        27'd37675152, 27'd36398028, 27'd35204650, 27'd34086883
    };

    function automatic logic [Q_W-1:0] mantissa(input logic [22:0] frac);
        return {1'b1, frac, 3'b000};
    endfunction

endpackage

// File: rtl/fp_div_seed_rom.sv
// Reciprocal seed lookup indexed by the top four denominator fraction bits.
module fp_div_seed_rom
    import fp_div_pkg::*;
(
    input  logic [3:0]     idx,
    output logic [Q_W-1:0] seed
);

    assign seed = SEED_ROM[idx];

endmodule

// File: rtl/fp_div.sv
// Goldschmidt mantissa-division datapath: operand muxes, shared 27x27 multiplier,
// A/B/C iteration registers. Remainder register present only with FP_DIV_REM_EN.
module fp_div
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inputNum,
    input  logic [31:0] inputDenom,
    input  logic        en_a,
    input  logic        en_b,
    input  logic        en_rem,
    output logic [53:0] out,
    output logic [26:0] tb_rega,
    output logic [26:0] tb_regb,
    output logic [26:0] tb_regc,
    input  logic [1:0]  sel_mux3,
    input  logic [1:0]  sel_mux4,
    output logic [26:0] rrem
);

    logic [Q_W-1:0] nm;
    logic [Q_W-1:0] dm;
    logic [Q_W-1:0] ia;
    logic [Q_W-1:0] mcand;
    logic [Q_W-1:0] mplier;
    logic [Q_W-1:0] p;
    logic [Q_W-1:0] reg_a;
    logic [Q_W-1:0] reg_b;
    logic [Q_W-1:0] reg_c;
    logic           unused_hi;

    assign nm = mantissa(inputNum[22:0]);
    assign dm = mantissa(inputDenom[22:0]);
    assign unused_hi = &{1'b0, inputNum[31:23], inputDenom[31:23]};

    fp_div_seed_rom u_seed_rom (
        .idx  (inputDenom[22:19]),
        .seed (ia)
    );

    always_comb begin
        mcand = nm;
        case (mcand_sel_e'(sel_mux4))
            MCAND_NUM: mcand = nm;
            MCAND_DEN: mcand = dm;
            MCAND_A:   mcand = reg_a;
            MCAND_B:   mcand = reg_b;
            default:   mcand = nm;
        endcase
    end

    always_comb begin
        mplier = ia;
        case (mplier_sel_e'(sel_mux3))
            MPLIER_SEED: mplier = ia;
            MPLIER_C:    mplier = reg_c;
            MPLIER_DEN:  mplier = dm;
            MPLIER_ONE:  mplier = ONE_Q126;
            default:     mplier = ia;
        endcase
    end

    assign out = {27'd0, mcand} * {27'd0, mplier};
    // Q2.52 product back to Q1.26: drop the integer carry bit and low fraction bits.
    assign p   = out[52:26];

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
        end else begin
            if (en_a) begin
                reg_a <= p;
            end
            if (en_b) begin
                reg_b <= p;
                reg_c <= '0 - p;
            end
        end
    end

    assign tb_rega = reg_a;
    assign tb_regb = reg_b;
    assign tb_regc = reg_c;

`ifdef FP_DIV_REM_EN
    logic [Q_W-1:0] rem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
        end else if (en_rem) begin
            rem_q <= nm - p;
        end
    end

    assign rrem = rem_q;
`else
    logic unused_rem;

    assign unused_rem = en_rem;
    assign rrem       = '0;
`endif

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: random operands against a behavioural
// Goldschmidt model plus directed reset, seed and select checks.
module tb_fp_div;

    localparam longint unsigned MASK = 64'h7FF_FFFF;
    localparam longint unsigned ONE  = 64'h400_0000;

    logic        clk;
    logic        reset;
    logic [31:0] inputNum;
    logic [31:0] inputDenom;
    logic        en_a;
    logic        en_b;
    logic        en_rem;
    logic [53:0] out;
    logic [26:0] tb_rega;
    logic [26:0] tb_regb;
    logic [26:0] tb_regc;
    logic [1:0]  sel_mux3;
    logic [1:0]  sel_mux4;
    logic [26:0] rrem;

    int n_tests = 0;
    int n_fail  = 0;

    longint unsigned ma, mb, mc, mrem, nm, dm, last_p;

    fp_div dut (
        .clk        (clk),
        .reset      (reset),
        .inputNum   (inputNum),
        .inputDenom (inputDenom),
        .en_a       (en_a),
        .en_b       (en_b),
        .en_rem     (en_rem),
        .out        (out),
        .tb_rega    (tb_rega),
        .tb_regb    (tb_regb),
        .tb_regc    (tb_regc),
        .sel_mux3   (sel_mux3),
        .sel_mux4   (sel_mux4),
        .rrem       (rrem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned seed_of(input int unsigned k);
        real r;
        r = (2.0 ** 26) / (1.0 + (real'(k) + 0.5) / 16.0);
        return longint'(r);
    endfunction

    function automatic longint unsigned mant(input logic [22:0] frac);
        return ONE + (longint'(frac) << 3);
    endfunction

    function automatic longint unsigned adiff(input longint unsigned x, input longint unsigned y);
        return (x > y) ? x - y : y - x;
    endfunction

    // One controller cycle: predict out before the edge, register contents after it.
    task automatic step(input logic [1:0] m4, input logic [1:0] m3,
                        input logic ea, input logic eb, input logic er);
        longint unsigned x, y, prod, pv;
        sel_mux4 = m4;
        sel_mux3 = m3;
        en_a     = ea;
        en_b     = eb;
        en_rem   = er;
        @(negedge clk);
        case (m4)
            2'd0:    x = nm;
            2'd1:    x = dm;
            2'd2:    x = ma;
            default: x = mb;
        endcase
        case (m3)
            2'd0:    y = seed_of(int'(inputDenom[22:19]));
            2'd1:    y = mc;
            2'd2:    y = dm;
            default: y = ONE;
        endcase
        prod = x * y;
        check("out", longint'(out), prod);
        pv = (prod >> 26) & MASK;
        last_p = pv;
        @(posedge clk);
        #1;
        if (ea) ma = pv;
        if (eb) begin
            mb = pv;
            mc = ((64'd1 << 27) - pv) & MASK;
        end
`ifdef FP_DIV_REM_EN
        if (er) mrem = (nm - pv) & MASK;
`endif
        check("reg_a", longint'(tb_rega), ma);
        check("reg_b", longint'(tb_regb), mb);
        check("reg_c", longint'(tb_regc), mc);
        check("rrem",  longint'(rrem),    mrem);
        en_a   = 1'b0;
        en_b   = 1'b0;
        en_rem = 1'b0;
    endtask

    task automatic set_ops(input logic [22:0] nf, input logic [22:0] df);
        inputNum   = {$urandom_range(511, 0) & 32'h1FF, 23'd0} | {9'd0, nf};
        inputDenom = {$urandom_range(511, 0) & 32'h1FF, 23'd0} | {9'd0, df};
        nm = mant(nf);
        dm = mant(df);
    endtask

    task automatic iterate();
        repeat (5) begin
            step(2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
            step(2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        end
        step(2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
    endtask

    // Compares the DUT quotient with the real-valued N/D, within tol LSBs.
    task automatic check_quot(input string tag, input logic [22:0] nf, input logic [22:0] df,
                              input longint unsigned tol);
        real q;
        longint unsigned qs, a;
        q  = (1.0 + real'(nf) / (2.0 ** 23)) / (1.0 + real'(df) / (2.0 ** 23));
        qs = longint'(q * (2.0 ** 26));
        a  = longint'(tb_rega);
        check(tag, (adiff(a, qs) <= tol) ? qs : a, qs);
    endtask

    initial begin
        logic [22:0] nf, df;
        longint signed rs;
        reset = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_rem = 1'b0;
        sel_mux3 = 2'b00; sel_mux4 = 2'b00;
        inputNum = '0; inputDenom = '0;
        ma = 0; mb = 0; mc = 0; mrem = 0; nm = 0; dm = 0; last_p = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Load something non-zero, then reset with every enable high.
        set_ops(23'($urandom), 23'($urandom));
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b1, 1'b1);
        reset = 1'b1; en_a = 1'b1; en_b = 1'b1; en_rem = 1'b1;
        sel_mux3 = 2'b01; sel_mux4 = 2'b10;
        @(posedge clk);
        #1;
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; en_rem = 1'b0;
        ma = 0; mb = 0; mc = 0; mrem = 0;
        check("rst_a", longint'(tb_rega), 0);
        check("rst_b", longint'(tb_regb), 0);
        check("rst_c", longint'(tb_regc), 0);
        check("rst_rem", longint'(rrem), 0);

        // N = D = 1.0
        set_ops(23'd0, 23'd0);
        step(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
        check("den_x_one", longint'(out), ONE << 26);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        check("seed_a", longint'(tb_rega), 64'h3E0F83E);
        step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        check("seed_b", longint'(tb_regb), 64'h3E0F83E);
        check("seed_c", longint'(tb_regc), 64'h41F07C2);
        iterate();
        check("one_a", (adiff(longint'(tb_rega), ONE) <= 2) ? ONE : longint'(tb_rega), ONE);
        check("one_b", (adiff(longint'(tb_regb), ONE) <= 2) ? ONE : longint'(tb_regb), ONE);
        rs = rrem[26] ? longint'(rrem) - (64'sd1 <<< 27) : longint'(rrem);
        check("one_rem", (rs >= -2 && rs <= 2) ? 0 : longint'(rrem), 0);

        // Directed operand pair from the divider's bring-up notes.
        nf = 23'b10001001011000000010000;
        df = 23'b01000001100000001011001;
        set_ops(nf, df);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        iterate();
        check_quot("dir_quot", nf, df, 4);

        // Both A and B loaded from one product; then hold with enables low.
        step(2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
        check("sim_a", longint'(tb_rega), last_p);
        check("sim_b", longint'(tb_regb), last_p);
        check("sim_c", longint'(tb_regc), ((64'd1 << 27) - last_p) & MASK);
        step(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);

        // Random operands through the full sequence.
        for (int i = 0; i < 10; i++) begin
            nf = 23'($urandom);
            df = 23'($urandom);
            set_ops(nf, df);
            step(2'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
            step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
            step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
            iterate();
            check_quot("rnd_quot", nf, df, 16);
            step(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
